// File: rtl/branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : branch_ctrl
// Description : Branch resolution controller: issues an ALU compare, waits
//               for the result (bounded), then loads the PC and flushes.
// Revision    : 1.0  initial release
// ============================================================================
module branch_ctrl #(
    parameter int PC_W    = 16,
    parameter int TIMEOUT = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            br_valid,
    output logic            br_ready,
    input  logic [2:0]      br_type,
    input  logic [PC_W-1:0] br_target,
    input  logic [PC_W-1:0] pc_next,
    output logic [2:0]      alub,
    output logic            alu_start,
    input  logic            cmp_done,
    input  logic            check,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_value,
    output logic            flush,
    output logic            stall,
    output logic            err,
    output logic [15:0]     taken_cnt,
    output logic [15:0]     br_cnt
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        WAIT    = 2'd2,
        RESOLVE = 2'd3
    } state_t;

    localparam logic [7:0]  C_TMO_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0] C_CNT_MAX  = 16'hFFFF;

    state_t          state_q;
    logic            br_ready_q;
    logic            alu_start_q;
    logic            pc_load_q;
    logic            flush_q;
    logic            stall_q;
    logic            err_q;
    logic [2:0]      alub_q;
    logic [PC_W-1:0] target_q;
    logic [PC_W-1:0] fall_q;
    logic [PC_W-1:0] pc_value_q;
    logic [7:0]      timer_q;
    logic [15:0]     taken_cnt_q;
    logic [15:0]     br_cnt_q;

    // Every output register is loaded with the value belonging to the state
    // being entered, so outputs line up cycle-for-cycle with state_q.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            br_ready_q  <= 1'b0;
            alu_start_q <= 1'b0;
            pc_load_q   <= 1'b0;
            flush_q     <= 1'b0;
            stall_q     <= 1'b0;
            err_q       <= 1'b0;
            alub_q      <= 3'd0;
            target_q    <= '0;
            fall_q      <= '0;
            pc_value_q  <= '0;
            timer_q     <= 8'd0;
            taken_cnt_q <= 16'd0;
            br_cnt_q    <= 16'd0;
        end else begin
            alu_start_q <= 1'b0;
            pc_load_q   <= 1'b0;
            flush_q     <= 1'b0;
            err_q       <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (br_valid && br_ready_q) begin
                        state_q     <= ISSUE;
                        target_q    <= br_target;
                        fall_q      <= pc_next;
                        alub_q      <= br_type;
                        br_ready_q  <= 1'b0;
                        stall_q     <= 1'b1;
                        alu_start_q <= 1'b1;
                    end else begin
                        br_ready_q  <= 1'b1;
                    end
                end
                ISSUE: begin
                    state_q <= WAIT;
                    timer_q <= 8'd0;
                end
                WAIT: begin
                    // A compare arriving on the last allowed cycle still wins.
                    if (cmp_done) begin
                        state_q    <= RESOLVE;
                        alub_q     <= 3'd0;
                        pc_load_q  <= 1'b1;
                        flush_q    <= check;
                        pc_value_q <= check ? target_q : fall_q;
                        if (br_cnt_q != C_CNT_MAX) begin
                            br_cnt_q <= br_cnt_q + 16'd1;
                        end
                        if (check && (taken_cnt_q != C_CNT_MAX)) begin
                            taken_cnt_q <= taken_cnt_q + 16'd1;
                        end
                    end else if (timer_q == C_TMO_LAST) begin
                        state_q    <= IDLE;
                        alub_q     <= 3'd0;
                        stall_q    <= 1'b0;
                        br_ready_q <= 1'b1;
                        err_q      <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 8'd1;
                    end
                end
                RESOLVE: begin
                    state_q    <= IDLE;
                    stall_q    <= 1'b0;
                    br_ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign br_ready  = br_ready_q;
    assign alub      = alub_q;
    assign alu_start = alu_start_q;
    assign pc_load   = pc_load_q;
    assign pc_value  = pc_value_q;
    assign flush     = flush_q;
    assign stall     = stall_q;
    assign err       = err_q;
    assign taken_cnt = taken_cnt_q;
    assign br_cnt    = br_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_branch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_ctrl
// Description : Directed plus randomized bench for branch_ctrl with a
//               transaction-level reference model checked every cycle.
// Revision    : 1.0  initial release
// ============================================================================
module tb_branch_ctrl;

    localparam int PC_W    = 16;
    localparam int TIMEOUT = 8;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            br_valid = 1'b0;
    logic [2:0]      br_type = 3'd0;
    logic [PC_W-1:0] br_target = '0;
    logic [PC_W-1:0] pc_next = '0;
    logic            cmp_done = 1'b0;
    logic            check = 1'b0;
    logic            br_ready, alu_start, pc_load, flush, stall, err;
    logic [2:0]      alub;
    logic [PC_W-1:0] pc_value;
    logic [15:0]     taken_cnt, br_cnt;

    branch_ctrl #(.PC_W(PC_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst), .br_valid(br_valid), .br_ready(br_ready),
        .br_type(br_type), .br_target(br_target), .pc_next(pc_next),
        .alub(alub), .alu_start(alu_start), .cmp_done(cmp_done), .check(check),
        .pc_load(pc_load), .pc_value(pc_value), .flush(flush), .stall(stall),
        .err(err), .taken_cnt(taken_cnt), .br_cnt(br_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: a branch is "in flight" from handshake until it is
    // resolved or times out; m_waits counts WAIT cycles entered so far.
    bit          m_on = 1'b0;
    bit          m_busy = 1'b0, m_resolve = 1'b0;
    int          m_waits = 0;
    bit          m_ready = 1'b0, m_alu_start = 1'b0, m_pc_load = 1'b0;
    bit          m_flush = 1'b0, m_stall = 1'b0, m_err = 1'b0;
    logic [2:0]  m_alub = 3'd0;
    logic [15:0] m_tgt = '0, m_nxt = '0, m_pc_value = '0;
    logic [15:0] m_tcnt = '0, m_bcnt = '0;

    always @(negedge clk) begin
        if (m_on) begin
            chk("br_ready",  32'(br_ready),  32'(m_ready));
            chk("alu_start", 32'(alu_start), 32'(m_alu_start));
            chk("alub",      32'(alub),      32'(m_alub));
            chk("stall",     32'(stall),     32'(m_stall));
            chk("pc_load",   32'(pc_load),   32'(m_pc_load));
            chk("pc_value",  32'(pc_value),  32'(m_pc_value));
            chk("flush",     32'(flush),     32'(m_flush));
            chk("err",       32'(err),       32'(m_err));
            chk("taken_cnt", 32'(taken_cnt), 32'(m_tcnt));
            chk("br_cnt",    32'(br_cnt),    32'(m_bcnt));
        end
        m_alu_start = 1'b0;
        m_pc_load   = 1'b0;
        m_flush     = 1'b0;
        m_err       = 1'b0;
        if (rst) begin
            m_on = 1'b1; m_busy = 1'b0; m_resolve = 1'b0; m_waits = 0;
            m_ready = 1'b0; m_stall = 1'b0; m_alub = 3'd0;
            m_pc_value = '0; m_tcnt = '0; m_bcnt = '0;
        end else if (m_resolve) begin
            m_resolve = 1'b0; m_ready = 1'b1; m_stall = 1'b0;
        end else if (!m_busy) begin
            if (br_valid && m_ready) begin
                m_busy = 1'b1; m_waits = 0; m_ready = 1'b0; m_stall = 1'b1;
                m_alu_start = 1'b1; m_alub = br_type;
                m_tgt = br_target; m_nxt = pc_next;
            end else begin
                m_ready = 1'b1;
            end
        end else if (m_waits == 0) begin
            m_waits = 1;
        end else if (cmp_done) begin
            m_busy = 1'b0; m_resolve = 1'b1; m_alub = 3'd0;
            m_pc_load = 1'b1; m_flush = check;
            m_pc_value = check ? m_tgt : m_nxt;
            if (m_bcnt != 16'hFFFF) m_bcnt = m_bcnt + 16'd1;
            if (check && m_tcnt != 16'hFFFF) m_tcnt = m_tcnt + 16'd1;
        end else if (m_waits == TIMEOUT) begin
            m_busy = 1'b0; m_alub = 3'd0; m_stall = 1'b0; m_ready = 1'b1; m_err = 1'b1;
        end else begin
            m_waits++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [2:0] t, input logic [15:0] tg, input logic [15:0] nx);
        br_valid = 1'b1; br_type = t; br_target = tg; pc_next = nx;
        step();
        br_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) step();
        chk("rst br_ready", 32'(br_ready), 32'd0);
        chk("rst pc_value", 32'(pc_value), 32'd0);
        chk("rst br_cnt",   32'(br_cnt),   32'd0);
        rst = 1'b0;
        step();
        chk("ready after rst", 32'(br_ready), 32'd1);

        // Taken branch, compare done in the first WAIT cycle.
        launch(3'b010, 16'h0040, 16'h0012);
        chk("issue alu_start", 32'(alu_start), 32'd1);
        chk("issue alub",      32'(alub),      32'd2);
        step();
        cmp_done = 1'b1; check = 1'b1;
        step();
        cmp_done = 1'b0;
        chk("taken pc_load",  32'(pc_load),   32'd1);
        chk("taken pc_value", 32'(pc_value),  32'h0040);
        chk("taken flush",    32'(flush),     32'd1);
        chk("taken tcnt",     32'(taken_cnt), 32'd1);
        chk("taken bcnt",     32'(br_cnt),    32'd1);
        step();

        // Not-taken branch after 4 WAIT cycles; valid held high throughout.
        br_valid = 1'b1; br_type = 3'd5; br_target = 16'h1234; pc_next = 16'h0012;
        step();
        cmp_done = 1'b1; check = 1'b1;
        step();
        cmp_done = 1'b0;
        repeat (3) step();
        cmp_done = 1'b1; check = 1'b0;
        step();
        cmp_done = 1'b0;
        chk("nt pc_load",  32'(pc_load),   32'd1);
        chk("nt pc_value", 32'(pc_value),  32'h0012);
        chk("nt flush",    32'(flush),     32'd0);
        chk("nt tcnt",     32'(taken_cnt), 32'd1);
        chk("nt bcnt",     32'(br_cnt),    32'd2);
        chk("nt ready",    32'(br_ready),  32'd0);
        step();
        step();
        br_valid = 1'b0;
        chk("b2b accepted", 32'(alu_start), 32'd1);

        // Timeout: no compare for TIMEOUT WAIT cycles.
        repeat (TIMEOUT) step();
        chk("tmo no err yet", 32'(err), 32'd0);
        step();
        chk("tmo err",     32'(err),      32'd1);
        chk("tmo pc_load", 32'(pc_load),  32'd0);
        chk("tmo ready",   32'(br_ready), 32'd1);
        chk("tmo bcnt",    32'(br_cnt),   32'd2);

        // Compare coinciding with the final WAIT cycle.
        launch(3'd1, 16'h0BEE, 16'h0C00);
        repeat (TIMEOUT) step();
        cmp_done = 1'b1; check = 1'b1;
        step();
        cmp_done = 1'b0;
        chk("last pc_load",  32'(pc_load),  32'd1);
        chk("last err",      32'(err),      32'd0);
        chk("last pc_value", 32'(pc_value), 32'h0BEE);
        step();

        // Reset in the middle of WAIT.
        launch(3'd7, 16'h5555, 16'h6666);
        step();
        step();
        rst = 1'b1; cmp_done = 1'b1; check = 1'b1;
        step();
        chk("midrst pc_load", 32'(pc_load), 32'd0);
        chk("midrst stall",   32'(stall),   32'd0);
        chk("midrst tcnt",    32'(taken_cnt), 32'd0);
        rst = 1'b0; cmp_done = 1'b0;
        step();

        // Saturation: preload counters one below the limit.
        dut.taken_cnt_q = 16'hFFFE;
        dut.br_cnt_q    = 16'hFFFE;
        m_tcnt = 16'hFFFE;
        m_bcnt = 16'hFFFE;
        for (int k = 0; k < 2; k++) begin
            launch(3'd3, 16'h0100, 16'h0200);
            cmp_done = 1'b1; check = 1'b1;
            step();
            step();
            cmp_done = 1'b0;
            step();
        end
        chk("sat tcnt", 32'(taken_cnt), 32'hFFFF);
        chk("sat bcnt", 32'(br_cnt),    32'hFFFF);

        // Randomized traffic under varying compare-arrival rates.
        for (int seg = 0; seg < 3; seg++) begin
            for (int c = 0; c < 1000; c++) begin
                rst       = ($urandom_range(199) == 0);
                br_valid  = $urandom_range(1);
                br_type   = 3'($urandom);
                br_target = 16'($urandom);
                pc_next   = 16'($urandom);
                check     = $urandom_range(1);
                cmp_done  = ($urandom_range(99) < (seg == 0 ? 5 : (seg == 1 ? 30 : 80)));
                step();
            end
        end
        rst = 1'b0; br_valid = 1'b0; cmp_done = 1'b0;
        repeat (2) step();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
